// File: rtl/flip_request_ctrl_pkg.sv
// Shared types and defaults for the cursor / flip-request controller.
// Holds the flip FSM state encoding, grid geometry defaults and button indices.
package flip_request_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } flip_state_t;

    localparam int DEF_GRID_W    = 5;
    localparam int DEF_GRID_H    = 5;
    localparam int DEF_TILE      = 32;
    localparam int DEF_ORIGIN_X  = 5;
    localparam int DEF_ORIGIN_Y  = 3;
    localparam int DEF_DEBOUNCE  = 4;
    localparam int DEF_FLIP_HOLD = 10;
    localparam int DEF_FLIP_GAP  = 4;

    localparam int VGAID_W = 32;

    localparam int NUM_BTN   = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_FLIP  = 4;

    // Index width that never collapses to zero bits for a size-1 range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton conditioner: 2-flop synchronizer, counting debouncer and a
// single-cycle pulse on each accepted press.
module btn_debounce
    import flip_request_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int             CW      = idx_w(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] arm_cnt;

    // armed blocks presses until a released level has been seen, so a button
    // held through reset stays silent until it is released and pressed again.
    // The synchronizer comes out of reset low, so this relies on DEBOUNCE_CYCLES > 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            stable  <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            arm_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            pulse  <= 1'b0;

            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt    <= '0;
                stable <= sync_b;
                pulse  <= sync_b & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (!armed) begin
                if (sync_b) begin
                    arm_cnt <= '0;
                end else if (arm_cnt == CNT_MAX) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flip_request_ctrl.sv
// Cursor navigation over a tile grid plus a timed flip request (HOLD then GAP)
// towards the board-state block; moves and flips are ignored while busy.
module flip_request_ctrl
    import flip_request_ctrl_pkg::*;
#(
    parameter int GRID_W          = DEF_GRID_W,
    parameter int GRID_H          = DEF_GRID_H,
    parameter int TILE            = DEF_TILE,
    parameter int ORIGIN_X        = DEF_ORIGIN_X,
    parameter int ORIGIN_Y        = DEF_ORIGIN_Y,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int FLIP_HOLD       = DEF_FLIP_HOLD,
    parameter int FLIP_GAP        = DEF_FLIP_GAP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_flip,
    input  logic               game_over,
    output logic [9:0]         x_topleft,
    output logic [8:0]         y_topleft,
    output logic [VGAID_W-1:0] VGAid,
    output logic               flip,
    output logic               busy,
    output flip_state_t        state_dbg
);

    localparam int ROW_W = idx_w(GRID_H);
    localparam int COL_W = idx_w(GRID_W);
    localparam int TW    = idx_w((FLIP_HOLD > FLIP_GAP) ? FLIP_HOLD : FLIP_GAP);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(GRID_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(GRID_W - 1);
    localparam logic [TW-1:0]    HOLD_LAST = TW'(FLIP_HOLD - 1);
    localparam logic [TW-1:0]    GAP_LAST  = TW'(FLIP_GAP - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;

    assign btn_raw = {btn_flip, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_raw[i]),
            .pulse(btn_pulse[i])
        );
    end

    flip_state_t      state;
    flip_state_t      state_nx;
    logic [TW-1:0]    tmr;
    logic [TW-1:0]    tmr_nx;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_nx;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nx;
    logic             move_en;

    assign move_en = (state == ST_IDLE);

    // Opposing pulses in the same cycle cancel; the two axes are independent.
    always_comb begin
        row_nx = row;
        col_nx = col;
        if (move_en) begin
            if (btn_pulse[BTN_UP] && !btn_pulse[BTN_DOWN]) begin
                row_nx = (row == '0) ? ROW_LAST : row - 1'b1;
            end else if (btn_pulse[BTN_DOWN] && !btn_pulse[BTN_UP]) begin
                row_nx = (row == ROW_LAST) ? '0 : row + 1'b1;
            end
            if (btn_pulse[BTN_LEFT] && !btn_pulse[BTN_RIGHT]) begin
                col_nx = (col == '0) ? COL_LAST : col - 1'b1;
            end else if (btn_pulse[BTN_RIGHT] && !btn_pulse[BTN_LEFT]) begin
                col_nx = (col == COL_LAST) ? '0 : col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            x_topleft <= 10'(ORIGIN_X);
            y_topleft <= 9'(ORIGIN_Y);
            VGAid     <= '0;
        end else begin
            row       <= row_nx;
            col       <= col_nx;
            x_topleft <= 10'(ORIGIN_X + int'(col_nx) * TILE);
            y_topleft <= 9'(ORIGIN_Y + int'(row_nx) * TILE);
            VGAid     <= VGAID_W'(int'(row_nx) * GRID_W + int'(col_nx));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    // game_over only gates the start of a request; a running HOLD always completes.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        case (state)
            ST_IDLE: begin
                if (btn_pulse[BTN_FLIP] && !game_over) begin
                    state_nx = ST_HOLD;
                    tmr_nx   = '0;
                end
            end
            ST_HOLD: begin
                if (tmr == HOLD_LAST) begin
                    state_nx = ST_GAP;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr == GAP_LAST) begin
                    state_nx = ST_IDLE;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    always_comb begin
        flip      = (state == ST_HOLD);
        busy      = (state == ST_HOLD) || (state == ST_GAP);
        state_dbg = state;
    end

endmodule

// File: tb/tb_flip_request_ctrl.sv
// Bench for flip_request_ctrl: table of button presses with expected cursor,
// then hand-written flip, game-over, glitch and reset sequences.
module tb_flip_request_ctrl;
    import flip_request_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               btn_up = 1'b0;
    logic               btn_down = 1'b0;
    logic               btn_left = 1'b0;
    logic               btn_right = 1'b0;
    logic               btn_flip = 1'b0;
    logic               game_over = 1'b0;
    logic [9:0]         x_topleft;
    logic [8:0]         y_topleft;
    logic [VGAID_W-1:0] VGAid;
    logic               flip;
    logic               busy;
    flip_state_t        state_dbg;

    flip_request_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_flip (btn_flip),
        .game_over(game_over),
        .x_topleft(x_topleft),
        .y_topleft(y_topleft),
        .VGAid    (VGAid),
        .flip     (flip),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  mask;
        logic [31:0] id;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected value queued, actual=%0d", name, actual);
        end else begin
            e = exp_q.pop_front();
            if (actual !== e) begin
                failures++;
                $display("FAIL %s: actual=%0d required=%0d", name, actual, e);
            end
        end
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right, 4 flip
    task automatic set_btn(input logic [4:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
        btn_flip  = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        set_btn(m);
        tick(8);
        set_btn(5'b0);
        tick(14);
    endtask

    task automatic move_check(input string name, input logic [4:0] m,
                              input logic [31:0] id, input logic [31:0] x,
                              input logic [31:0] y);
        push(id);
        push(x);
        push(y);
        press(m);
        check({name, "_id"}, VGAid);
        check({name, "_x"}, 32'(x_topleft));
        check({name, "_y"}, 32'(y_topleft));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic wait_flip_rise(output int n);
        n = 0;
        while (flip !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int hi;
        int gap;

        vecs[0]  = '{5'b01000, 1, 37, 3};
        vecs[1]  = '{5'b01000, 2, 69, 3};
        vecs[2]  = '{5'b01000, 3, 101, 3};
        vecs[3]  = '{5'b01000, 4, 133, 3};
        vecs[4]  = '{5'b00010, 9, 133, 35};
        vecs[5]  = '{5'b00011, 9, 133, 35};
        vecs[6]  = '{5'b01100, 9, 133, 35};
        vecs[7]  = '{5'b01000, 5, 5, 35};
        vecs[8]  = '{5'b00100, 9, 133, 35};
        vecs[9]  = '{5'b00001, 4, 133, 3};
        vecs[10] = '{5'b00001, 24, 133, 131};
        vecs[11] = '{5'b00010, 4, 133, 3};
        vecs[12] = '{5'b00110, 8, 101, 35};
        vecs[13] = '{5'b01001, 4, 133, 3};
        vecs[14] = '{5'b10100, 3, 101, 3};

        tick(3);
        rst_n = 1'b1;
        tick(10);
        push(5); push(3); push(0); push(0); push(0); push(32'(ST_IDLE));
        check("rst_x", 32'(x_topleft));
        check("rst_y", 32'(y_topleft));
        check("rst_id", VGAid);
        check("rst_flip", 32'(flip));
        check("rst_busy", 32'(busy));
        check("rst_state", 32'(state_dbg));

        move_check("left_wrap", 5'b00100, 4, 133, 3);
        move_check("up_wrap", 5'b00001, 24, 133, 131);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            move_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].id, vecs[i].x, vecs[i].y);
        end
        move_check("to8", 5'b00010, 8, 101, 35);
        move_check("to9", 5'b01000, 9, 133, 35);

        // Flip at cell 9 with a right press and a game_over rise during HOLD.
        push(1); push(10); push(4); push(9);
        btn_flip = 1'b1;
        wait_flip_rise(n);
        btn_flip = 1'b0;
        check("flip_rise", 32'(flip));
        btn_right = 1'b1;
        hi = 0;
        gap = 0;
        for (int c = 0; c < 40; c++) begin
            if (flip === 1'b1 && busy === 1'b1) hi++;
            else if (flip === 1'b0 && busy === 1'b1) gap++;
            else break;
            if (c == 3) game_over = 1'b1;
            if (c == 8) btn_right = 1'b0;
            tick();
        end
        btn_right = 1'b0;
        game_over = 1'b0;
        tick(15);
        check("flip_hold_cycles", 32'(hi));
        check("flip_gap_cycles", 32'(gap));
        check("hold_id_frozen", VGAid);

        move_check("go_to5", 5'b01000, 5, 5, 35);
        move_check("go_to10", 5'b00010, 10, 5, 67);
        move_check("go_to15", 5'b00010, 15, 5, 99);

        // game_over blocks a new flip but not moves.
        game_over = 1'b1;
        push(0);
        n = 0;
        btn_flip = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 8) btn_flip = 1'b0;
            if (flip === 1'b1 || busy === 1'b1) n++;
            tick();
        end
        check("gameover_no_flip", 32'(n));
        move_check("gameover_move", 5'b01000, 16, 37, 99);
        game_over = 1'b0;

        // Bounce: two 1-cycle glitches then a 3-cycle pulse.
        push(16);
        btn_right = 1'b1; tick(1); btn_right = 1'b0; tick(2);
        btn_right = 1'b1; tick(1); btn_right = 1'b0; tick(2);
        btn_right = 1'b1; tick(3); btn_right = 1'b0; tick(12);
        check("glitch_no_move", VGAid);

        // Reset in the middle of HOLD, with right held across reset release.
        push(1);
        btn_flip = 1'b1;
        wait_flip_rise(n);
        btn_flip = 1'b0;
        check("rst_hold_rise", 32'(flip));
        tick(3);
        btn_right = 1'b1;
        rst_n = 1'b0;
        #1;
        push(0); push(0); push(0);
        check("rst_hold_flip", 32'(flip));
        check("rst_hold_busy", 32'(busy));
        check("rst_hold_id", VGAid);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        push(0);
        check("held_through_reset", VGAid);
        btn_right = 1'b0;
        tick(12);
        move_check("repress_after_reset", 5'b01000, 1, 37, 3);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected: actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
